otter_ifetch: RTL

Instruction-fetch stage directly downstream of the program counter. It takes the current PC address, issues a single-outstanding read on the instruction-memory request/grant/response bus, and captures the returned word into an instruction register with a valid/ack handshake toward decode/control. It supports flush on redirects (jal/jalr/branch/trap/mret), discards stale responses, and reports bus errors and response timeouts.

---
 rtl/otter_ifetch_if.sv | 38 +++
 rtl/otter_ifetch.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/otter_ifetch_if.sv
// Instruction-fetch bus bundle: PC/control inputs, instruction-memory
// request/grant/response channel, and the instruction register handshake.
interface otter_ifetch_if;
  // From PC stage / control
  logic [31:0] pc_addr;
  logic        fetch_req;
  logic        flush;
  logic        ir_ack;
  // Instruction memory channel
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;
  // Toward decode / control
  logic [31:0] ir;
  logic [31:0] ir_addr;
  logic        ir_valid;
  logic        fetch_err;
  logic        fetch_busy;

  // Fetch unit side
  modport master (
    input  pc_addr, fetch_req, flush, ir_ack,
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata, imem_err,
    output ir, ir_addr, ir_valid, fetch_err, fetch_busy
  );

  // Environment side: control, PC stage and instruction memory
  modport slave (
    output pc_addr, fetch_req, flush, ir_ack,
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata, imem_err,
    input  ir, ir_addr, ir_valid, fetch_err, fetch_busy
  );
endinterface

// File: rtl/otter_ifetch.sv
// Instruction-fetch stage: single-outstanding read on the imem bus, result
// captured into an instruction register with valid/ack toward decode.
// Supports flush, stale-response draining, bus errors and response timeout.
// Every output is a register or a decode of the state register.
module otter_ifetch #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic           clk,
  input  logic           rst,
  otter_ifetch_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  // The counter value seen on the last allowed waiting cycle.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [2:0]  r_state,     w_state_nxt;
  logic [15:0] r_cnt,       w_cnt_nxt;
  logic [31:0] r_imem_addr, w_imem_addr_nxt;
  logic [31:0] r_ir,        w_ir_nxt;
  logic [31:0] r_ir_addr,   w_ir_addr_nxt;
  logic        r_ir_valid,  w_ir_valid_nxt;
  logic        r_fetch_err, w_fetch_err_nxt;
  logic        w_to_hit;

  assign w_to_hit = (r_cnt == TO_LAST);

  // Next-state and register-load decode
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = '0;
    w_imem_addr_nxt = r_imem_addr;
    w_ir_nxt        = r_ir;
    w_ir_addr_nxt   = r_ir_addr;
    w_ir_valid_nxt  = r_ir_valid;
    w_fetch_err_nxt = r_fetch_err;

    case (r_state)
      S_IDLE: begin
        if (bus.fetch_req && !bus.flush) begin
          w_state_nxt     = S_REQ;
          w_imem_addr_nxt = bus.pc_addr & 32'hFFFF_FFFC;
        end
      end

      S_REQ: begin
        if (bus.flush) begin
          // A granted request still has a response in flight to throw away.
          w_state_nxt = bus.imem_gnt ? S_DRAIN : S_IDLE;
        end else if (bus.imem_gnt) begin
          w_state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        if (bus.flush) begin
          // A response arriving with the flush is consumed right here,
          // so nothing is left to drain.
          w_state_nxt = bus.imem_rvalid ? S_IDLE : S_DRAIN;
        end else if (bus.imem_rvalid) begin
          w_state_nxt     = S_HOLD;
          w_ir_nxt        = bus.imem_rdata;
          w_ir_addr_nxt   = r_imem_addr;
          w_fetch_err_nxt = bus.imem_err;
          w_ir_valid_nxt  = 1'b1;
        end else if (w_to_hit) begin
          w_state_nxt     = S_ERR;
          w_ir_nxt        = '0;
          w_ir_addr_nxt   = r_imem_addr;
          w_fetch_err_nxt = 1'b1;
          w_ir_valid_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end

      S_HOLD: begin
        if (bus.flush) begin
          w_state_nxt     = S_IDLE;
          w_ir_valid_nxt  = 1'b0;
          w_fetch_err_nxt = 1'b0;
        end else if (bus.ir_ack) begin
          w_ir_valid_nxt  = 1'b0;
          w_fetch_err_nxt = 1'b0;
          if (bus.fetch_req) begin
            w_state_nxt     = S_REQ;
            w_imem_addr_nxt = bus.pc_addr & 32'hFFFF_FFFC;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end

      S_DRAIN: begin
        if (bus.imem_rvalid) begin
          w_state_nxt = S_IDLE;
        end else if (w_to_hit) begin
          w_state_nxt     = S_ERR;
          w_ir_nxt        = '0;
          w_ir_addr_nxt   = r_imem_addr;
          w_fetch_err_nxt = 1'b1;
          w_ir_valid_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end

      S_ERR: begin
        w_state_nxt = S_ERR;
      end

      default: begin
        w_state_nxt     = S_IDLE;
        w_ir_valid_nxt  = 1'b0;
        w_fetch_err_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_imem_addr <= '0;
      r_ir        <= '0;
      r_ir_addr   <= '0;
      r_ir_valid  <= 1'b0;
      r_fetch_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_imem_addr <= w_imem_addr_nxt;
      r_ir        <= w_ir_nxt;
      r_ir_addr   <= w_ir_addr_nxt;
      r_ir_valid  <= w_ir_valid_nxt;
      r_fetch_err <= w_fetch_err_nxt;
    end
  end

  assign bus.imem_req   = (r_state == S_REQ);
  assign bus.imem_addr  = r_imem_addr;
  assign bus.fetch_busy = (r_state != S_IDLE);
  assign bus.ir         = r_ir;
  assign bus.ir_addr    = r_ir_addr;
  assign bus.ir_valid   = r_ir_valid;
  assign bus.fetch_err  = r_fetch_err;

endmodule
